data_stack_ctrl: RTL and testbench

- Sequencer for the 4-bit data stack.
- Accepts one stack-machine command at a time over a valid/ready handshake and expands it into the data stack's push/pop cycles: single-cycle push, pop, or replace (push+pop).
- Tracks logical depth, detects overflow/underflow before touching the stack, and returns a result nibble plus error status.
- Sits between instruction decode and the data stack.

---
 rtl/data_stack_ctrl_if.sv | 22 ++
 rtl/data_stack_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_data_stack_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_stack_ctrl_if.sv
// Command/response channel between instruction decode and the data stack
// sequencer. Decode is the master (issues commands); the sequencer is the slave.
interface data_stack_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_imm;
    logic       resp_valid;
    logic [3:0] resp_data;
    logic       resp_err;
    logic [1:0] resp_err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_imm,
        input  cmd_ready, resp_valid, resp_data, resp_err, resp_err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm,
        output cmd_ready, resp_valid, resp_data, resp_err, resp_err_code
    );
endinterface

// File: rtl/data_stack_ctrl.sv
// Data stack sequencer: accepts one stack-machine command at a time, checks it
// against the logical depth, and expands it into push / pop / replace cycles on
// the attached data stack. Stack enables are combinational from state and the
// operands latched at accept; handshake/response outputs are registered.
module data_stack_ctrl #(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    data_stack_ctrl_if.slave   bus,
    output logic [DEPTH_W-1:0] depth,
    output logic               ds_push_en,
    output logic               ds_pop_en,
    output logic [3:0]         ds_push_data,
    input  logic [3:0]         ds_tos,
    input  logic [3:0]         ds_ntos
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;

    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [3:0]         imm_reg;
    logic [3:0]         a_reg;          // top of stack at accept
    logic [3:0]         b_reg;          // next-of-top at accept
    logic               err_reg;        // latched command was rejected
    logic [DEPTH_W-1:0] depth_reg;
    logic               ready_reg;
    logic               resp_valid_reg;
    logic [3:0]         resp_data_reg;
    logic               resp_err_reg;
    logic [1:0]         resp_code_reg;

    logic               under_next;
    logic               over_next;
    logic               accept;
    logic [3:0]         alu_result;

    assign accept     = bus.cmd_valid && ready_reg;
    // B op A: next-of-top is the left operand for SUB.
    assign alu_result = (op_reg == OP_SUB) ? (b_reg - a_reg) : (b_reg + a_reg);

    // Reject decision for the command being offered, against the current depth.
    always_comb begin
        under_next = 1'b0;
        over_next  = 1'b0;
        case (bus.cmd_op)
            OP_PUSH:                 over_next  = (depth_reg == DEPTH_FULL);
            OP_POP, OP_DROP:         under_next = (depth_reg == '0);
            OP_DUP: begin
                under_next = (depth_reg == '0);
                over_next  = (depth_reg == DEPTH_FULL);
            end
            OP_SWAP, OP_ADD, OP_SUB: under_next = (depth_reg < DEPTH_W'(2));
            default: ;
        endcase
    end

    // Data stack enables per sequence step; nothing is driven in IDLE or after a reject.
    always_comb begin
        ds_push_en   = 1'b0;
        ds_pop_en    = 1'b0;
        ds_push_data = 4'h0;
        case (state_reg)
            S1: if (!err_reg) begin
                case (op_reg)
                    OP_PUSH: begin ds_push_en = 1'b1; ds_push_data = imm_reg; end
                    OP_DUP:  begin ds_push_en = 1'b1; ds_push_data = a_reg;   end
                    OP_POP, OP_DROP, OP_SWAP, OP_ADD, OP_SUB: ds_pop_en = 1'b1;
                    default: ;
                endcase
            end
            S2: begin
                // Replace step: both enables overwrite the new top.
                ds_push_en   = 1'b1;
                ds_pop_en    = 1'b1;
                ds_push_data = (op_reg == OP_SWAP) ? a_reg : alu_result;
            end
            S3: begin
                ds_push_en   = 1'b1;
                ds_push_data = b_reg;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered handshake, response and depth tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_reg         <= OP_NOP;
            imm_reg        <= 4'h0;
            a_reg          <= 4'h0;
            b_reg          <= 4'h0;
            err_reg        <= 1'b0;
            depth_reg      <= '0;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 4'h0;
            resp_err_reg   <= 1'b0;
            resp_code_reg  <= 2'd0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 4'h0;
            resp_err_reg   <= 1'b0;
            resp_code_reg  <= 2'd0;

            // The response cycle is the final cycle of a command: commit depth there.
            if (resp_valid_reg && !resp_err_reg) begin
                case (op_reg)
                    OP_PUSH, OP_DUP:                 depth_reg <= depth_reg + 1'b1;
                    OP_POP, OP_DROP, OP_ADD, OP_SUB: depth_reg <= depth_reg - 1'b1;
                    default: ;
                endcase
            end

            case (state_reg)
                IDLE: if (accept) begin
                    op_reg    <= bus.cmd_op;
                    imm_reg   <= bus.cmd_imm;
                    a_reg     <= ds_tos;
                    b_reg     <= ds_ntos;
                    state_reg <= S1;
                    ready_reg <= 1'b0;
                    err_reg   <= under_next || over_next;
                    if (under_next || over_next) begin
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        resp_code_reg  <= under_next ? ERR_UNDER : ERR_OVER;
                    end else if (bus.cmd_op != OP_SWAP && bus.cmd_op != OP_ADD &&
                                 bus.cmd_op != OP_SUB) begin
                        resp_valid_reg <= 1'b1;
                        if (bus.cmd_op == OP_POP)
                            resp_data_reg <= ds_tos;
                    end
                end
                S1: begin
                    if (!err_reg && (op_reg == OP_SWAP || op_reg == OP_ADD ||
                                     op_reg == OP_SUB)) begin
                        state_reg <= S2;
                        if (op_reg != OP_SWAP) begin
                            resp_valid_reg <= 1'b1;
                            resp_data_reg  <= alu_result;
                        end
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                S2: begin
                    if (op_reg == OP_SWAP) begin
                        state_reg      <= S3;
                        resp_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = ready_reg;
    assign bus.resp_valid    = resp_valid_reg;
    assign bus.resp_data     = resp_data_reg;
    assign bus.resp_err      = resp_err_reg;
    assign bus.resp_err_code = resp_code_reg;
    assign depth             = depth_reg;

endmodule

// File: tb/tb_data_stack_ctrl.sv
// Bench for data_stack_ctrl: models the attached 16-entry data stack, keeps a
// reference logical stack, and scoreboards every response.
module tb_data_stack_ctrl;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] depth;
    logic       ds_push_en, ds_pop_en;
    logic [3:0] ds_push_data, ds_tos, ds_ntos;

    data_stack_ctrl_if bus();

    data_stack_ctrl #(.STACK_DEPTH(16), .DEPTH_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .depth        (depth),
        .ds_push_en   (ds_push_en),
        .ds_pop_en    (ds_pop_en),
        .ds_push_data (ds_push_data),
        .ds_tos       (ds_tos),
        .ds_ntos      (ds_ntos)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int issued = 0;
    int accept_cyc = 0;
    int resp_cyc_q[$];
    logic [6:0] exp_q[$];      // {data, err, code}
    logic [5:0] en_log[$];     // {push, pop, data}, data zeroed when no push
    logic [3:0] ref_stk[$];    // reference logical stack, back = top

    always @(posedge clk) cyc <= cyc + 1;

    // Physical data stack attached to the controller.
    logic [3:0] mem [0:15];
    int ptr = 0;
    always_comb begin
        ds_tos  = (ptr >= 1) ? mem[ptr-1] : 4'h0;
        ds_ntos = (ptr >= 2) ? mem[ptr-2] : 4'h0;
    end
    always @(posedge clk) begin
        if (rst) ptr <= 0;
        else if (ds_push_en && ds_pop_en) begin
            if (ptr >= 1) mem[ptr-1] <= ds_push_data;
        end else if (ds_push_en) begin
            if (ptr < 16) begin mem[ptr] <= ds_push_data; ptr <= ptr + 1; end
        end else if (ds_pop_en) begin
            if (ptr >= 1) ptr <= ptr - 1;
        end
    end

    // Response scoreboard and enable trace.
    always @(negedge clk) begin
        if (ds_push_en || ds_pop_en)
            en_log.push_back(ds_push_en ? {1'b1, ds_pop_en, ds_push_data} : 6'b01_0000);
        if (bus.resp_valid === 1'b1) begin
            resp_cnt++;
            resp_cyc_q.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: got data=%h err=%b code=%0d, required no response",
                         bus.resp_data, bus.resp_err, bus.resp_err_code);
            end else begin
                automatic logic [6:0] e = exp_q.pop_front();
                $display("resp #%0d: data=%h err=%b code=%0d depth=%0d",
                         resp_cnt, bus.resp_data, bus.resp_err, bus.resp_err_code, depth);
                if ({bus.resp_data, bus.resp_err, bus.resp_err_code} !== e) begin
                    n_bad++;
                    $display("FAIL resp_payload: got data=%h err=%b code=%0d, required data=%h err=%b code=%0d",
                             bus.resp_data, bus.resp_err, bus.resp_err_code, e[6:3], e[2], e[1:0]);
                end
            end
        end
    end

    // Reference behaviour: push the expected response and update the logical stack.
    task automatic model_cmd(input logic [2:0] op, input logic [3:0] imm);
        automatic logic [3:0] d = 4'h0;
        automatic logic [3:0] a, b;
        automatic logic       e = 1'b0;
        automatic logic [1:0] c = 2'd0;
        automatic int         n = ref_stk.size();
        case (op)
            OP_PUSH: if (n == 16) begin e = 1; c = 2; end else ref_stk.push_back(imm);
            OP_POP:  if (n < 1) begin e = 1; c = 1; end else d = ref_stk.pop_back();
            OP_DUP:  if (n < 1) begin e = 1; c = 1; end
                     else if (n == 16) begin e = 1; c = 2; end
                     else begin a = ref_stk[n-1]; ref_stk.push_back(a); end
            OP_DROP: if (n < 1) begin e = 1; c = 1; end else void'(ref_stk.pop_back());
            OP_SWAP: if (n < 2) begin e = 1; c = 1; end
                     else begin
                         a = ref_stk.pop_back(); b = ref_stk.pop_back();
                         ref_stk.push_back(a); ref_stk.push_back(b);
                     end
            OP_ADD, OP_SUB: if (n < 2) begin e = 1; c = 1; end
                     else begin
                         a = ref_stk.pop_back(); b = ref_stk.pop_back();
                         d = (op == OP_ADD) ? b + a : b - a;
                         ref_stk.push_back(d);
                     end
            default: ;
        endcase
        exp_q.push_back({d, e, c});
        issued++;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [3:0] imm);
        automatic int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;
        while (bus.cmd_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
        end
        @(posedge clk); #1;
        accept_cyc    = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_resp();
        automatic int n = 0;
        while (resp_cnt < issued && n < 40) begin @(negedge clk); n++; end
        if (resp_cnt < issued) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: responses=%0d, required %0d", resp_cnt, issued);
            resp_cnt = issued;
        end
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] imm);
        model_cmd(op, imm);
        drive_cmd(op, imm);
        wait_resp();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ref_stk.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_imm = 4'h0;
        pulse_reset();
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", bus.cmd_ready); end
        n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL reset_depth: got %0d required 0", depth); end
        n_cmp++; if ({bus.resp_valid, bus.resp_data, bus.resp_err, bus.resp_err_code} !== 8'h00) begin
            n_bad++; $display("FAIL reset_resp: got v=%b d=%h e=%b c=%0d required all 0",
                              bus.resp_valid, bus.resp_data, bus.resp_err, bus.resp_err_code); end
        n_cmp++; if ({ds_push_en, ds_pop_en, ds_push_data} !== 6'h00) begin
            n_bad++; $display("FAIL reset_enables: got push=%b pop=%b data=%h required 0",
                              ds_push_en, ds_pop_en, ds_push_data); end
    endtask

    task automatic test_add();
        send(OP_PUSH, 4'd3);
        send(OP_PUSH, 4'd5);
        en_log.delete();
        send(OP_ADD, 4'd0);
        n_cmp++; if (en_log.size() != 2) begin n_bad++; $display("FAIL add_enable_count: got %0d required 2", en_log.size()); end
        else begin
            n_cmp++; if (en_log[0] !== 6'b01_0000 || en_log[1] !== 6'b11_1000) begin
                n_bad++; $display("FAIL add_enables: got %b,%b required 010000,111000", en_log[0], en_log[1]); end
        end
        n_cmp++; if (depth !== 5'd1) begin n_bad++; $display("FAIL add_depth: got %0d required 1", depth); end
        n_cmp++; if (ds_tos !== 4'd8) begin n_bad++; $display("FAIL add_tos: got %h required 8", ds_tos); end
        send(OP_DROP, 4'd0);
    endtask

    task automatic test_sub();
        send(OP_PUSH, 4'd2);
        send(OP_PUSH, 4'd7);
        send(OP_SUB, 4'd0);
        n_cmp++; if (depth !== 5'd1) begin n_bad++; $display("FAIL sub_depth: got %0d required 1", depth); end
        send(OP_POP, 4'd0);
        n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL pop_depth: got %0d required 0", depth); end
    endtask

    task automatic test_swap();
        send(OP_PUSH, 4'd1);
        send(OP_PUSH, 4'd4);
        en_log.delete();
        resp_cyc_q.delete();
        send(OP_SWAP, 4'd0);
        n_cmp++; if (en_log.size() != 3) begin n_bad++; $display("FAIL swap_enable_count: got %0d required 3", en_log.size()); end
        else begin
            n_cmp++; if (en_log[0] !== 6'b01_0000 || en_log[1] !== 6'b11_0100 || en_log[2] !== 6'b10_0001) begin
                n_bad++; $display("FAIL swap_enables: got %b,%b,%b required 010000,110100,100001",
                                  en_log[0], en_log[1], en_log[2]); end
        end
        n_cmp++; if (ds_tos !== 4'd1 || ds_ntos !== 4'd4) begin
            n_bad++; $display("FAIL swap_order: got tos=%h ntos=%h required tos=1 ntos=4", ds_tos, ds_ntos); end
        n_cmp++; if (depth !== 5'd2) begin n_bad++; $display("FAIL swap_depth: got %0d required 2", depth); end
        n_cmp++; if (resp_cyc_q.size() != 1 || resp_cyc_q[0] - accept_cyc + 1 != 3) begin
            n_bad++; $display("FAIL swap_latency: got resp in cycle %0d after accept, required 3",
                              (resp_cyc_q.size() > 0) ? resp_cyc_q[0] - accept_cyc + 1 : -1); end
    endtask

    task automatic test_underflow();
        send(OP_POP, 4'd0);
        send(OP_POP, 4'd0);
        en_log.delete();
        send(OP_POP, 4'd0);
        n_cmp++; if (en_log.size() != 0) begin n_bad++; $display("FAIL under_pop_enables: got %0d enable cycles required 0", en_log.size()); end
        n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL under_pop_depth: got %0d required 0", depth); end
        send(OP_PUSH, 4'd9);
        en_log.delete();
        send(OP_ADD, 4'd0);
        send(OP_SWAP, 4'd0);
        n_cmp++; if (en_log.size() != 0) begin n_bad++; $display("FAIL under_add_enables: got %0d enable cycles required 0", en_log.size()); end
        n_cmp++; if (depth !== 5'd1) begin n_bad++; $display("FAIL under_add_depth: got %0d required 1", depth); end
        send(OP_DROP, 4'd0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send(OP_PUSH, 4'(i + 3));
        n_cmp++; if (depth !== 5'd16) begin n_bad++; $display("FAIL full_depth: got %0d required 16", depth); end
        en_log.delete();
        send(OP_PUSH, 4'd9);
        send(OP_DUP, 4'd0);
        n_cmp++; if (en_log.size() != 0) begin n_bad++; $display("FAIL over_enables: got %0d enable cycles required 0", en_log.size()); end
        n_cmp++; if (depth !== 5'd16) begin n_bad++; $display("FAIL over_depth: got %0d required 16", depth); end
        send(OP_POP, 4'd0);
        send(OP_DUP, 4'd0);
        n_cmp++; if (ds_tos !== 4'd1 || depth !== 5'd16) begin
            n_bad++; $display("FAIL dup_refill: got tos=%h depth=%0d required tos=1 depth=16", ds_tos, depth); end
    endtask

    task automatic test_reset_mid();
        automatic int base;
        pulse_reset();
        send(OP_PUSH, 4'd1);
        send(OP_PUSH, 4'd4);
        base = resp_cnt;
        drive_cmd(OP_SWAP, 4'd0);       // now in S1
        @(posedge clk); #1;             // now in S2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_stk.delete();
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b required 1", bus.cmd_ready); end
        n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL rstmid_depth: got %0d required 0", depth); end
        n_cmp++; if (ds_push_en !== 1'b0 || ds_pop_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_quiet: got push=%b pop=%b resp_valid=%b required 0",
                              ds_push_en, ds_pop_en, bus.resp_valid); end
        repeat (3) @(negedge clk);
        n_cmp++; if (resp_cnt != base) begin n_bad++; $display("FAIL rstmid_noresp: got %0d responses required %0d", resp_cnt, base); end
        send(OP_PUSH, 4'd6);
        n_cmp++; if (depth !== 5'd1 || ds_tos !== 4'd6) begin
            n_bad++; $display("FAIL rstmid_push: got depth=%0d tos=%h required depth=1 tos=6", depth, ds_tos); end
    endtask

    task automatic test_back_to_back();
        automatic int n = 0;
        resp_cyc_q.delete();
        model_cmd(OP_PUSH, 4'hA);
        model_cmd(OP_DUP, 4'h0);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_PUSH; bus.cmd_imm = 4'hA;
        @(posedge clk); #1;            // ready was 1 in IDLE: accepted
        bus.cmd_op = OP_DUP; bus.cmd_imm = 4'h0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_resp();
        n_cmp++; if (resp_cyc_q.size() != 2 || resp_cyc_q[1] - resp_cyc_q[0] != 2) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d cycles required 2",
                              (resp_cyc_q.size() == 2) ? resp_cyc_q[1] - resp_cyc_q[0] : -1); end
        n_cmp++; if (depth !== 5'd3 || ds_tos !== 4'hA || ds_ntos !== 4'hA) begin
            n_bad++; $display("FAIL b2b_state: got depth=%0d tos=%h ntos=%h required 3,a,a", depth, ds_tos, ds_ntos); end
        send(OP_NOP, 4'h0);
        send(OP_SUB, 4'h0);
        n_cmp++; if (ds_tos !== 4'h0 || depth !== 5'd2) begin
            n_bad++; $display("FAIL sub_zero: got tos=%h depth=%0d required 0,2", ds_tos, depth); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_swap();
        test_underflow();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL leftover_expect: got %0d pending required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
